// File: rtl/sp_ram_arb_pkg.sv
// Shared constants and helpers for the sp_ram round-robin arbiter.
package sp_ram_arb_pkg;

    localparam int unsigned MAX_REQ          = 8;
    localparam int unsigned MAX_READ_LATENCY = 4;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
module rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // One extra bit on the sum so ptr+k never overflows before the explicit wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one sp_ram functional port among NUM_REQ requesters with round-robin
// grants and routes each read response back to its issuer after READ_LATENCY.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 2,
    parameter  int unsigned ADDR_WIDTH   = 8,
    parameter  int unsigned DATA_WIDTH   = 64,
    parameter  int unsigned COL_WIDTH    = 8,
    parameter  int unsigned READ_LATENCY = 1,
    localparam int unsigned NUM_COL      = DATA_WIDTH / COL_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ram_hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*NUM_COL-1:0]    req_wmask,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_clk_en,
    output logic                          ram_rdw_en,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_data_in,
    output logic [NUM_COL-1:0]            ram_data_mask_in,
    input  logic [DATA_WIDTH-1:0]         ram_data_out
);

    localparam int unsigned PW = ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("sp_ram_arbiter: NUM_REQ out of range");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("sp_ram_arbiter: READ_LATENCY out of range");
    end

    logic [PW-1:0]           rr_ptr;
    logic [NUM_REQ-1:0]      gnt;
    logic [PW-1:0]           gnt_idx;
    logic                    accept;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [PW-1:0]           pipe_id [READ_LATENCY];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (rst_n & ~ram_hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        ram_clk_en       = accept;
        ram_rdw_en       = 1'b0;
        ram_addr         = '0;
        ram_data_in      = '0;
        ram_data_mask_in = '0;
        if (accept) begin
            ram_rdw_en       = req_we[gnt_idx];
            ram_addr         = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_data_in      = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            ram_data_mask_in = req_wmask[gnt_idx*NUM_COL +: NUM_COL];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept & ~req_we[gnt_idx];
            for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
            end
            if (accept) begin
                rr_ptr <= (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
            end
        end
        pipe_id[0] <= gnt_idx;
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
            pipe_id[s] <= pipe_id[s-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rst_n && pipe_vld[READ_LATENCY-1]) begin
            rsp_valid[pipe_id[READ_LATENCY-1]] = 1'b1;
            rsp_rdata                          = ram_data_out;
        end
    end

endmodule
